// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache<->memory request interface.
// The initiator side imports NBE from here so both ends agree on the wr_mem width.
package mem_if_pkg;
    localparam int MEM_DWIDTH = 32;
    localparam int NBE        = MEM_DWIDTH / 8;
    localparam int CW         = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, REL} state_t;
endpackage

// File: rtl/mem_bram_be.sv
// Single-port word RAM with per-byte write enables and a registered, read-first output.
module mem_bram_be #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32,
    parameter int NBE    = DWIDTH / 8
) (
    input  logic              clock,
    input  logic [NBE-1:0]    we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);
    logic [DWIDTH-1:0] r_mem [2**AWIDTH];

    // Read samples the old word when a write hits the same address.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NBE; k++) begin
            if (we[k]) r_mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
        rdata <= r_mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one request, waits LATENCY cycles, strobes ready_mem,
// then holds off until the initiator drops its level request (four-phase handshake).
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int AWIDTH  = 9,
    parameter int DWIDTH  = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rd_mem,
    input  logic [DWIDTH/8-1:0]   wr_mem,
    input  logic [AWIDTH-1:0]     addr_mem,
    input  logic [DWIDTH-1:0]     data_in,
    output logic [DWIDTH-1:0]     data_out,
    output logic                  ready_mem,
    output logic                  busy_mem
);
    localparam int NB = DWIDTH / 8;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [NB-1:0]     r_be;
    logic              r_is_wr;
    logic              r_ready;
    logic              r_busy;
    logic [DWIDTH-1:0] r_dout;

    logic              w_req;
    logic [NB-1:0]     w_we;
    logic [DWIDTH-1:0] w_rdata;

    assign w_req = rd_mem | (|wr_mem);
    // The write lands on the same edge that raises ready_mem.
    assign w_we  = (r_state == RESP && r_is_wr) ? r_be : '0;

    mem_bram_be #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NBE(NB)) u_ram (
        .clock (clock),
        .we    (w_we),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_is_wr <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_ready <= 1'b0;
            if (r_ready && !r_is_wr) r_dout <= w_rdata;
            case (r_state)
                IDLE: if (w_req) begin
                    // Write wins over a simultaneous read.
                    r_addr  <= addr_mem;
                    r_wdata <= data_in;
                    r_be    <= wr_mem;
                    r_is_wr <= |wr_mem;
                    r_cnt   <= CW'(LATENCY - 1);
                    r_busy  <= 1'b1;
                    r_state <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= RESP;
                end
                RESP: begin
                    r_ready <= 1'b1;
                    r_state <= REL;
                end
                REL: if (!w_req) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM output is live during the ready cycle of a read; afterwards the held copy is shown.
    assign data_out  = (r_ready && !r_is_wr) ? w_rdata : r_dout;
    assign ready_mem = r_ready;
    assign busy_mem  = r_busy;
endmodule
